// File: rtl/tx_top_control_module.sv
// tx_top_control_module
// UART transmit-side controller. Pops one byte at a time from the TX FIFO,
// waits out the FIFO read latency, then presents the byte to the UART TX
// core and holds it until the core reports completion. An optional idle
// gap can be forced between bytes.
// Optional SEND watchdog: define TX_CTRL_TIMEOUT_EN to enable it. Without
// the macro SEND waits indefinitely and Err_Sig is tied low.

module tx_top_control_module #(
    parameter int DATA_W         = 8,
    parameter int RD_LAT         = 1,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Empty_Sig,
    output logic              Read_Req_Sig,
    input  logic [DATA_W-1:0] FIFO_Read_Data,
    output logic              TX_En_Sig,
    output logic [DATA_W-1:0] TX_Data,
    input  logic              TX_Done_Sig,
    output logic              Busy_Sig,
    output logic [15:0]       Tx_Count,
    output logic              Err_Sig
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_SEND    = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // Latency counter value at which FIFO data is valid and gets captured.
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    // Last value of the gap counter before returning to IDLE.
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    // Where a finished (or abandoned) byte sends the FSM.
    localparam state_t AFTER_SEND = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t     state;
    logic [1:0] lat_cnt;
    logic [7:0] gap_cnt;

`ifdef TX_CTRL_TIMEOUT_EN
    // Last watchdog count value; the timeout fires on the edge that would
    // complete TIMEOUT_CYCLES cycles spent in SEND.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        err_q;
`endif

    // Reject out-of-range configurations at elaboration time.
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("tx_top_control_module: RD_LAT must be in 1..3");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("tx_top_control_module: GAP_CYCLES must be in 0..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("tx_top_control_module: TIMEOUT_CYCLES must be in 1..65535");
    end

    // Main controller: one registered FSM that also owns every registered output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            lat_cnt      <= 2'd0;
            gap_cnt      <= 8'd0;
            Read_Req_Sig <= 1'b0;
            TX_En_Sig    <= 1'b0;
            TX_Data      <= '0;
            Tx_Count     <= 16'd0;
`ifdef TX_CTRL_TIMEOUT_EN
            wd_cnt       <= 16'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            // Read request and error are single-cycle pulses by default.
            Read_Req_Sig <= 1'b0;
`ifdef TX_CTRL_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (!Empty_Sig) begin
                        Read_Req_Sig <= 1'b1;
                        lat_cnt      <= 2'd0;
                        state        <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    // Empty_Sig is deliberately ignored: the byte is already popped.
                    if (lat_cnt == LAT_LAST) begin
                        TX_Data   <= FIFO_Read_Data;
                        TX_En_Sig <= 1'b1;
`ifdef TX_CTRL_TIMEOUT_EN
                        wd_cnt    <= 16'd0;
`endif
                        state     <= ST_SEND;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end

                ST_SEND: begin
                    // A completion on the same edge as the timeout counts as success.
                    if (TX_Done_Sig) begin
                        TX_En_Sig <= 1'b0;
                        Tx_Count  <= Tx_Count + 16'd1;
                        gap_cnt   <= 8'd0;
                        state     <= AFTER_SEND;
                    end
`ifdef TX_CTRL_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        TX_En_Sig <= 1'b0;
                        err_q     <= 1'b1;
                        gap_cnt   <= 8'd0;
                        state     <= AFTER_SEND;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Busy is decoded straight from the state register.
    assign Busy_Sig = (state != ST_IDLE);

`ifdef TX_CTRL_TIMEOUT_EN
    assign Err_Sig = err_q;
`else
    assign Err_Sig = 1'b0;
`endif

endmodule

// File: tb/tb_tx_top_control_module.sv
// tb_tx_top_control_module
// Bench for tx_top_control_module with RD_LAT=1, GAP_CYCLES=4, TIMEOUT_CYCLES=16.
// Honours TX_CTRL_TIMEOUT_EN the same way the design does.

`timescale 1ns/1ps

module tb_tx_top_control_module;

    localparam int DATA_W         = 8;
    localparam int RD_LAT         = 1;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Empty_Sig;
    logic        Read_Req_Sig;
    logic [7:0]  FIFO_Read_Data;
    logic        TX_En_Sig;
    logic [7:0]  TX_Data;
    logic        TX_Done_Sig;
    logic        Busy_Sig;
    logic [15:0] Tx_Count;
    logic        Err_Sig;

    tx_top_control_module #(
        .DATA_W        (DATA_W),
        .RD_LAT        (RD_LAT),
        .GAP_CYCLES    (GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .Empty_Sig     (Empty_Sig),
        .Read_Req_Sig  (Read_Req_Sig),
        .FIFO_Read_Data(FIFO_Read_Data),
        .TX_En_Sig     (TX_En_Sig),
        .TX_Data       (TX_Data),
        .TX_Done_Sig   (TX_Done_Sig),
        .Busy_Sig      (Busy_Sig),
        .Tx_Count      (Tx_Count),
        .Err_Sig       (Err_Sig)
    );

    // 100 MHz clock.
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Bench-side FIFO and TX core.
    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    int         fifo_cd     = 0;
    logic [7:0] fifo_out    = 8'h00;
    bit         empty_ovr_en = 1'b0;
    logic       empty_ovr   = 1'b1;
    int         done_delay  = 0;
    int         en_hold     = 0;
    bit         stray_done  = 1'b0;

    // Observed event timestamps (negedge indices).
    int neg_idx       = 0;
    int last_req_neg  = -1;
    int last_rise_neg = -1;
    int last_fall_neg = -1;
    int req_total     = 0;
    int fall_total    = 0;
    int err_total     = 0;
    int min_gap       = 1000000;
    bit prev_en       = 1'b0;

    // Reference model: tracks edge timestamps of the transfer in flight.
    int          edge_idx  = 0;
    int          idle_from = 0;
    int          req_edge  = 0;
    int          en_edge   = 0;
    bit          m_valid   = 1'b0;
    bit          m_out     = 1'b0;
    bit          m_req     = 1'b0;
    bit          m_en      = 1'b0;
    bit          m_err     = 1'b0;
    logic [7:0]  m_data    = 8'h00;
    logic [7:0]  inflight  = 8'h00;
    logic [15:0] m_count   = 16'h0000;

    // Predict the outputs following each rising edge from the timing rules:
    // request when idle and not empty, data RD_LAT+1 edges after the request,
    // done (or watchdog) ends the byte, next request no earlier than GAP+1 edges later.
    always @(posedge CLK) begin
        edge_idx++;
        m_req = 1'b0;
        m_err = 1'b0;
        if (RST) begin
            m_valid   = 1'b1;
            m_out     = 1'b0;
            m_en      = 1'b0;
            m_data    = 8'h00;
            m_count   = 16'h0000;
            idle_from = edge_idx + 1;
        end else if (m_valid) begin
            if (m_en) begin
                if (TX_Done_Sig) begin
                    m_en      = 1'b0;
                    m_out     = 1'b0;
                    m_count   = m_count + 16'd1;
                    idle_from = edge_idx + GAP_CYCLES + 1;
                end
`ifdef TX_CTRL_TIMEOUT_EN
                else if (edge_idx == en_edge + TIMEOUT_CYCLES) begin
                    m_en      = 1'b0;
                    m_out     = 1'b0;
                    m_err     = 1'b1;
                    idle_from = edge_idx + GAP_CYCLES + 1;
                end
`endif
            end else if (m_out) begin
                if (edge_idx == req_edge + RD_LAT + 1) begin
                    m_en    = 1'b1;
                    en_edge = edge_idx;
                    m_data  = inflight;
                end
            end else if (edge_idx >= idle_from && !Empty_Sig) begin
                m_req    = 1'b1;
                m_out    = 1'b1;
                req_edge = edge_idx;
                inflight = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s @neg %0d: got 0x%0h, want 0x%0h", name, neg_idx, actual, expected);
        end
    endtask

    task automatic failBound(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired @neg %0d", name, neg_idx);
    endtask

    // Drive Empty_Sig from the bench FIFO unless a test overrides it.
    task automatic applyStimulus();
        Empty_Sig = empty_ovr_en ? empty_ovr : (fifo_q.size() == 0);
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifo_q.push_back(b);
        sb_q.push_back(b);
        applyStimulus();
    endtask

    // One cycle: compare at the falling edge, then update FIFO/TX-core inputs.
    task automatic cycleStep();
        @(negedge CLK);
        neg_idx++;
        if (m_valid) begin
            checkOutput("read_req", 32'(Read_Req_Sig), 32'(m_req));
            checkOutput("tx_en",    32'(TX_En_Sig),    32'(m_en));
            checkOutput("busy",     32'(Busy_Sig),     32'(m_out || (edge_idx + 1 < idle_from)));
            checkOutput("tx_count", 32'(Tx_Count),     32'(m_count));
            checkOutput("err",      32'(Err_Sig),      32'(m_err));
            if (m_en) checkOutput("tx_data", 32'(TX_Data), 32'(m_data));
        end
        if (TX_En_Sig && !prev_en) last_rise_neg = neg_idx;
        if (!TX_En_Sig && prev_en) begin
            last_fall_neg = neg_idx;
            fall_total++;
        end
        prev_en = TX_En_Sig;
        if (Err_Sig) err_total++;
        if (fifo_cd > 0) begin
            fifo_cd--;
            FIFO_Read_Data = (fifo_cd == 0) ? fifo_out : 8'($urandom);
        end else begin
            FIFO_Read_Data = 8'($urandom);
        end
        if (Read_Req_Sig) begin
            req_total++;
            if (last_fall_neg >= 0 && neg_idx - last_fall_neg < min_gap) min_gap = neg_idx - last_fall_neg;
            last_req_neg = neg_idx;
            fifo_out = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
            fifo_cd  = RD_LAT;
        end
        if (TX_En_Sig) en_hold++;
        else en_hold = 0;
        TX_Done_Sig = TX_En_Sig ? (done_delay > 0 && en_hold >= done_delay) : stray_done;
        applyStimulus();
    endtask

    task automatic applyReset(input int cycles);
        RST = 1'b1;
        repeat (cycles) cycleStep();
        RST = 1'b0;
    endtask

    task automatic waitEnRise(input int budget, input string name);
        int n = 0;
        while (!TX_En_Sig && n < budget) begin
            cycleStep();
            n++;
        end
        if (!TX_En_Sig) failBound(name);
    endtask

    task automatic waitEnFall(input int budget, input string name);
        int n = 0;
        while (TX_En_Sig && n < budget) begin
            cycleStep();
            n++;
        end
        if (TX_En_Sig) failBound(name);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          dly;
        logic [7:0]  exp_data;
        logic [15:0] exp_count;
    } vec_t;

    // Hard stop in case the bench itself wedges.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec_t tbl[5];
        int   req_before;
        int   fall_before;
        int   err_before;
        int   n;
        int   rand_pushes;

        tbl[0] = '{8'hA5, 1, 8'hA5, 16'd1};
        tbl[1] = '{8'h00, 2, 8'h00, 16'd2};
        tbl[2] = '{8'hFF, 5, 8'hFF, 16'd3};
        tbl[3] = '{8'h3C, 1, 8'h3C, 16'd4};
        tbl[4] = '{8'h81, 7, 8'h81, 16'd5};

        RST            = 1'b1;
        TX_Done_Sig    = 1'b0;
        FIFO_Read_Data = 8'h00;
        Empty_Sig      = 1'b1;

        // Reset held 3 cycles while the FIFO claims to be non-empty.
        $display("[TB] reset with Empty_Sig low");
        empty_ovr_en = 1'b1;
        empty_ovr    = 1'b0;
        applyStimulus();
        applyReset(3);
        checkOutput("t1_tx_data", 32'(TX_Data), 32'h0);
        checkOutput("t1_reqs", 32'(req_total), 32'd0);
        empty_ovr_en = 1'b0;
        applyStimulus();
        repeat (3) cycleStep();

        // Single byte, completion after 10 cycles.
        $display("[TB] single byte 0x55");
        done_delay = 10;
        pushByte(8'h55);
        waitEnRise(10, "t2_rise");
        checkOutput("t2_data", 32'(TX_Data), 32'h55);
        checkOutput("t2_lat", 32'(last_rise_neg - last_req_neg), 32'(RD_LAT + 1));
        waitEnFall(20, "t2_fall");
        checkOutput("t2_en_len", 32'(last_fall_neg - last_rise_neg), 32'd10);
        checkOutput("t2_count", 32'(Tx_Count), 32'd1);

        // Three bytes separated by the forced gap.
        $display("[TB] three bytes with gap");
        applyReset(1);
        done_delay  = 3;
        req_before  = req_total;
        fall_before = fall_total;
        min_gap     = 1000000;
        last_fall_neg = -1;
        pushByte(8'h01);
        pushByte(8'h02);
        pushByte(8'h03);
        n = 0;
        while (fall_total - fall_before < 3 && n < 200) begin
            cycleStep();
            n++;
        end
        if (fall_total - fall_before < 3) failBound("t3_done");
        checkOutput("t3_reqs", 32'(req_total - req_before), 32'd3);
        checkOutput("t3_gap", 32'(min_gap), 32'(GAP_CYCLES + 1));
        checkOutput("t3_count", 32'(Tx_Count), 32'd3);
        n = 0;
        while (Busy_Sig && n < 20) begin
            cycleStep();
            n++;
        end
        checkOutput("t3_busy", 32'(Busy_Sig), 32'd0);

        // Stray done in IDLE, Empty_Sig toggling in RD_WAIT.
        $display("[TB] stray done and empty toggling");
        stray_done = 1'b1;
        cycleStep();
        stray_done = 1'b0;
        repeat (2) cycleStep();
        checkOutput("t4_idle_busy", 32'(Busy_Sig), 32'd0);
        checkOutput("t4_idle_count", 32'(Tx_Count), 32'd3);
        req_before = req_total;
        pushByte(8'h4D);
        n = 0;
        while (!Read_Req_Sig && n < 10) begin
            cycleStep();
            n++;
        end
        if (!Read_Req_Sig) failBound("t4_req");
        empty_ovr_en = 1'b1;
        empty_ovr    = 1'b0;
        applyStimulus();
        n = 0;
        while (!TX_En_Sig && n < 10) begin
            cycleStep();
            empty_ovr = ~empty_ovr;
            applyStimulus();
            n++;
        end
        empty_ovr_en = 1'b0;
        applyStimulus();
        checkOutput("t4_data", 32'(TX_Data), 32'h4D);
        waitEnFall(20, "t4_fall");
        repeat (GAP_CYCLES + 3) cycleStep();
        checkOutput("t4_reqs", 32'(req_total - req_before), 32'd1);

        // Reset during SEND.
        $display("[TB] reset during send");
        done_delay = 0;
        pushByte(8'h99);
        waitEnRise(20, "t5_rise");
        repeat (3) cycleStep();
        RST = 1'b1;
        cycleStep();
        RST = 1'b0;
        checkOutput("t5_en", 32'(TX_En_Sig), 32'd0);
        checkOutput("t5_count", 32'(Tx_Count), 32'd0);
        checkOutput("t5_busy", 32'(Busy_Sig), 32'd0);
        checkOutput("t5_data", 32'(TX_Data), 32'h0);
        cycleStep();

        // Table-driven single-byte transfers.
        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) begin
            done_delay = tbl[i].dly;
            pushByte(tbl[i].data);
            waitEnRise(30, "tbl_rise");
            checkOutput("tbl_data", 32'(TX_Data), 32'(tbl[i].exp_data));
            waitEnFall(30, "tbl_fall");
            checkOutput("tbl_count", 32'(Tx_Count), 32'(tbl[i].exp_count));
        end

        // Watchdog behaviour when the TX core never completes.
        $display("[TB] no completion from TX core");
        done_delay = 0;
        err_before = err_total;
        pushByte(8'h77);
        waitEnRise(30, "t6_rise");
`ifdef TX_CTRL_TIMEOUT_EN
        waitEnFall(TIMEOUT_CYCLES + 5, "t6_fall");
        checkOutput("t6_en_len", 32'(last_fall_neg - last_rise_neg), 32'(TIMEOUT_CYCLES));
        cycleStep();
        checkOutput("t6_err_pulses", 32'(err_total - err_before), 32'd1);
        checkOutput("t6_count", 32'(Tx_Count), 32'd5);
`else
        repeat (100) cycleStep();
        checkOutput("t6_en_held", 32'(TX_En_Sig), 32'd1);
        checkOutput("t6_err_pulses", 32'(err_total - err_before), 32'd0);
        checkOutput("t6_count", 32'(Tx_Count), 32'd5);
`endif
        applyReset(1);

        // Randomized traffic against the reference model.
        $display("[TB] randomized traffic");
        rand_pushes = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) begin
                pushByte(8'($urandom));
                rand_pushes++;
            end
            if (!TX_En_Sig) done_delay = $urandom_range(1, 8);
            stray_done = !TX_En_Sig && ($urandom_range(0, 7) == 0);
            cycleStep();
        end
        stray_done = 1'b0;
        n = 0;
        while ((fifo_q.size() > 0 || Busy_Sig) && n < 400) begin
            cycleStep();
            n++;
        end
        if (fifo_q.size() > 0 || Busy_Sig) failBound("rand_drain");
        checkOutput("rand_count", 32'(Tx_Count), 32'(rand_pushes));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
